// File: rtl/fa.sv
// Single-bit full adder used as the datapath bit of the serial adder.
module fa (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one fa instance processes operand bits LSB first, one per clock,
// with a registered carry looped back; result appears WIDTH cycles after start.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_sum_sh;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_s;
    logic             r_cout;

    logic             w_fa_s;
    logic             w_fa_cout;
    logic [WIDTH-1:0] w_sum_next;

    fa u_fa (
        .a    (r_a_sh[0]),
        .b    (r_b_sh[0]),
        .cin  (r_carry),
        .s    (w_fa_s),
        .cout (w_fa_cout)
    );

    // New sum bit enters at the MSB so that after WIDTH shifts bit 0 holds the LSB.
    assign w_sum_next = {w_fa_s, r_sum_sh[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_sum_sh <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
            r_s      <= '0;
            r_cout   <= 1'b0;
        end else begin
            case (r_state)
                ST_SHIFT: begin
                    r_sum_sh <= w_sum_next;
                    r_a_sh   <= {1'b0, r_a_sh[WIDTH-1:1]};
                    r_b_sh   <= {1'b0, r_b_sh[WIDTH-1:1]};
                    r_carry  <= w_fa_cout;
                    if (r_cnt == LAST_CNT) begin
                        r_s     <= w_sum_next;
                        r_cout  <= w_fa_cout;
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    // Unused encoding 3 behaves as IDLE.
                    if (start) begin
                        r_a_sh   <= a;
                        r_b_sh   <= b;
                        r_carry  <= cin;
                        r_cnt    <= '0;
                        r_sum_sh <= '0;
                        r_state  <= ST_SHIFT;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign s    = r_s;
    assign cout = r_cout;
    assign busy = (r_state == ST_SHIFT);
    assign done = (r_state == ST_DONE);

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: WIDTH=8 directed/random/protocol tests and a WIDTH=4 exhaustive sweep.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       start8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       cin8 = 1'b0;
    logic [7:0] s8;
    logic       cout8, busy8, done8;

    logic       start4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic       cin4 = 1'b0;
    logic [3:0] s4;
    logic       cout4, busy4, done4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .s(s8), .cout(cout8), .busy(busy8), .done(done8)
    );

    serial_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .cin(cin4),
        .s(s4), .cout(cout4), .busy(busy4), .done(done4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one 8-bit addition; operands are scrambled right after the accepting edge.
    task automatic do_add8(input logic [7:0] av, input logic [7:0] bv, input logic ci,
                           output logic [7:0] so, output logic co, output int lat,
                           output int busy_cnt, output bit overlap, output logic done_after);
        a8 = av; b8 = bv; cin8 = ci; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
        lat = 1; busy_cnt = 0; overlap = 1'b0;
        while (!done8 && lat < 40) begin
            if (busy8) busy_cnt++;
            tick();
            lat++;
        end
        if (busy8 && done8) overlap = 1'b1;
        so = s8; co = cout8;
        tick();
        done_after = done8;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        checks++; if (s8 !== 8'h00) begin errors++; $display("FAIL reset_s: got %h want 00", s8); end
        checks++; if (cout8 !== 1'b0) begin errors++; $display("FAIL reset_cout: got %b want 0", cout8); end
        checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy8); end
        checks++; if (done8 !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done8); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_directed();
        logic [7:0] av[3] = '{8'h5A, 8'hFF, 8'hFF};
        logic [7:0] bv[3] = '{8'h3C, 8'h01, 8'hFF};
        logic       cv[3] = '{1'b0, 1'b0, 1'b1};
        logic [7:0] so; logic co; int lat, bc; bit ov; logic da;
        logic [8:0] exp;
        for (int k = 0; k < 3; k++) begin
            do_add8(av[k], bv[k], cv[k], so, co, lat, bc, ov, da);
            exp = 9'(av[k]) + 9'(bv[k]) + 9'(cv[k]);
            checks++; if ({co, so} !== exp) begin errors++; $display("FAIL directed_sum[%0d]: got %h want %h", k, {co, so}, exp); end
            checks++; if (lat !== 9) begin errors++; $display("FAIL directed_latency[%0d]: got %0d want 9", k, lat); end
            checks++; if (bc !== 8) begin errors++; $display("FAIL directed_busy_cycles[%0d]: got %0d want 8", k, bc); end
            checks++; if (ov || da !== 1'b0) begin errors++; $display("FAIL directed_done_pulse[%0d]: overlap %0b done_after %b want 0 0", k, ov, da); end
        end
    endtask

    task automatic test_hold();
        logic [7:0] so; logic co; int lat, bc; bit ov; logic da;
        do_add8(8'h12, 8'h34, 1'b1, so, co, lat, bc, ov, da);
        for (int k = 0; k < 5; k++) tick();
        checks++; if ({cout8, s8} !== 9'h047) begin errors++; $display("FAIL hold_result: got %h want 047", {cout8, s8}); end
        checks++; if (busy8 !== 1'b0 || done8 !== 1'b0) begin errors++; $display("FAIL hold_idle: busy %b done %b want 0 0", busy8, done8); end
    endtask

    task automatic test_random8();
        logic [7:0] av, bv, so; logic ci, co; int lat, bc; bit ov; logic da;
        logic [8:0] exp;
        for (int k = 0; k < 20; k++) begin
            av = 8'($urandom); bv = 8'($urandom); ci = 1'($urandom);
            do_add8(av, bv, ci, so, co, lat, bc, ov, da);
            exp = 9'(av) + 9'(bv) + 9'(ci);
            checks++;
            if ({co, so} !== exp || lat !== 9 || bc !== 8 || ov || da !== 1'b0) begin
                errors++;
                $display("FAIL random8[%0d]: %h+%h+%b got %h lat %0d busy %0d want %h lat 9 busy 8", k, av, bv, ci, {co, so}, lat, bc, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] a1, b1, a2, b2;
        logic       c1, c2;
        int         done_cyc[$];
        logic [8:0] res[$];
        a1 = 8'($urandom); b1 = 8'($urandom); c1 = 1'($urandom);
        a2 = 8'($urandom); b2 = 8'($urandom); c2 = 1'($urandom);
        a8 = a1; b8 = b1; cin8 = c1; start8 = 1'b1;
        tick();
        for (int c = 1; c < 60 && res.size() < 2; c++) begin
            if (c == 1 || c == 11) begin
                a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
            end
            checks++; if (busy8 && done8) begin errors++; $display("FAIL b2b_busy_done_overlap: cycle %0d", c); end
            if (done8) begin
                done_cyc.push_back(c);
                res.push_back({cout8, s8});
                if (res.size() == 1) begin a8 = a2; b8 = b2; cin8 = c2; end
                else start8 = 1'b0;
            end
            tick();
        end
        start8 = 1'b0;
        checks++;
        if (res.size() != 2) begin
            errors++; $display("FAIL b2b_done_count: got %0d want 2", res.size());
        end else begin
            checks++; if (res[0] !== 9'(a1) + 9'(b1) + 9'(c1)) begin errors++; $display("FAIL b2b_first: got %h want %h", res[0], 9'(a1) + 9'(b1) + 9'(c1)); end
            checks++; if (res[1] !== 9'(a2) + 9'(b2) + 9'(c2)) begin errors++; $display("FAIL b2b_second: got %h want %h", res[1], 9'(a2) + 9'(b2) + 9'(c2)); end
            checks++; if (done_cyc[1] - done_cyc[0] !== 10) begin errors++; $display("FAIL b2b_spacing: got %0d want 10", done_cyc[1] - done_cyc[0]); end
        end
        tick(); tick();
    endtask

    task automatic test_reset_mid();
        logic [7:0] so; logic co; int lat, bc; bit ov; logic da;
        bit saw_done;
        a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b0; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", busy8); end
        checks++; if ({cout8, s8} !== 9'h000) begin errors++; $display("FAIL midrst_result: got %h want 000", {cout8, s8}); end
        saw_done = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (done8) saw_done = 1'b1;
            tick();
        end
        checks++; if (saw_done) begin errors++; $display("FAIL midrst_no_done: got done pulse want none"); end
        do_add8(8'h01, 8'h01, 1'b0, so, co, lat, bc, ov, da);
        checks++; if ({co, so} !== 9'h002) begin errors++; $display("FAIL midrst_after: got %h want 002", {co, so}); end
    endtask

    task automatic test_sweep4();
        logic [3:0] av, bv; logic ci;
        int lat, pulses;
        bit ov;
        for (int i = 0; i < 512; i++) begin
            av = i[3:0]; bv = i[7:4]; ci = i[8];
            a4 = av; b4 = bv; cin4 = ci; start4 = 1'b1;
            tick();
            start4 = 1'b0;
            a4 = 4'($urandom); b4 = 4'($urandom); cin4 = 1'($urandom);
            lat = 1; ov = 1'b0;
            while (!done4 && lat < 20) begin
                if (busy4 && done4) ov = 1'b1;
                tick(); lat++;
            end
            checks++;
            if ({cout4, s4} !== 5'(av) + 5'(bv) + 5'(ci) || lat !== 5) begin
                errors++;
                $display("FAIL sweep4_sum: %h+%h+%b got %h lat %0d want %h lat 5", av, bv, ci, {cout4, s4}, lat, 5'(av) + 5'(bv) + 5'(ci));
            end
            pulses = done4 ? 1 : 0;
            if (busy4 && done4) ov = 1'b1;
            tick();
            if (done4) pulses++;
            if (busy4 && done4) ov = 1'b1;
            checks++;
            if (pulses !== 1 || ov) begin
                errors++;
                $display("FAIL sweep4_protocol: case %0d pulses %0d overlap %0b want 1 0", i, pulses, ov);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_hold();
        test_random8();
        test_back_to_back();
        test_reset_mid();
        test_sweep4();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
